layer_seq: RTL and testbench
============================

Name: layer_seq

Overview:
- Layer sequencer in front of the tiny_dnn_top datapath.
- Holds a small table of per-layer descriptors: geometry plus weight/bias beat counts.
- For each layer in turn, drives the datapath's configuration buses and steps it through weight load, bias load and batch run.
- Monitors the src/dst stream handshakes to decide when each phase is finished; a host sees only cfg-write, start, abort and done.

Parameters:
- MAX_LAYERS, 4, number of descriptor entries; index width LW = clog2(MAX_LAYERS), minimum 1.
- F_NUM, 16, filter lanes in the datapath; bias beat count must be ≤ F_NUM.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  descriptor write strobe
- cfg_idx  in  LW  descriptor index to write
- cfg_data  in  112  descriptor, LSB first: ss[11:0] id[15:12] is[25:16] ih[30:26] iw[35:31] ds[47:36] od[51:48] os[61:52] oh[66:62] ow[71:67] fs[79:72] kh[82:80] kw[85:83] wn[98:86] (weight beats) bn[103:99] (bias beats) ns[111:104] (samples per run)
- nlayers  in  LW+1  number of layers to execute, 1..MAX_LAYERS
- start  in  1  begin sequence (pulse)
- abort  in  1  synchronous abort
- src_valid, src_ready  in  1 each  src stream handshake (monitored only)
- dst_valid, dst_ready, dst_last  in  1 each  dst stream handshake (monitored only)
- wwrite, bwrite, run  out  1 each  datapath phase controls
- ss,id,is,ih,iw,ds,od,os,oh,ow,fs,kh,kw  out  widths as in the descriptor  active-layer geometry
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at sequence completion
- layer  out  LW  active layer index
- err  out  1  sticky bad-descriptor flag, cleared on start

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; table contents undefined.
- States:
  - IDLE
  - LOAD: 1 cycle. Geometry registers are loaded from the table for the current layer.
  - WLD: wwrite=1. Counts beats of src_valid&src_ready up to wn.
  - BLD: bwrite=1. Counts beats up to bn.
  - RUN: run=1. Counts beats of dst_valid&dst_ready&dst_last up to ns.
  - NEXT: 1 cycle. Increments the layer index; goes to LOAD if index < nlayers, else DONE.
  - DONE: done=1 for 1 cycle, then IDLE.
- Phase skipping:
  - wn==0 skips WLD.
  - bn==0 skips BLD.
  - ns==0 is illegal: set err and go to DONE.
- Geometry outputs are registered. They change only in LOAD and stay stable through WLD, BLD and RUN.
- wwrite, bwrite and run are registered.
  - Phase exit is decided on the cycle the final beat handshakes.
  - The control deasserts on the following cycle. Exactly wn, bn and ns beats are counted; none extra.
- Latency: start to wwrite high is 2 cycles (IDLE→LOAD→WLD).
- busy is 1 in every state except IDLE. It falls in the cycle DONE is exited.
- Table writes:
  - cfg_we is accepted only in IDLE.
  - While busy, the write is ignored (table unchanged) and err is set.
- start:
  - In IDLE it clears err, latches nlayers, sets layer=0 and enters LOAD.
  - While busy it is ignored.
  - nlayers==0 or nlayers>MAX_LAYERS: set err and go to DONE without pulsing any phase control.
- bn>F_NUM: set err, clamp count to F_NUM, continue.
- abort, any state: on the next edge go to IDLE, deassert wwrite/bwrite/run, busy=0, no done pulse. Geometry outputs hold their last value.
- abort and start in the same cycle: abort wins.
- Asynchronous reset mid-sequence: immediate return to reset values.
- Beat counters are 13 bits wide and do not wrap; they are compared with ==.

Optional Feature:
- Macro LAYER_SEQ_PERF_EN.
- When defined:
  - Adds output perf_cyc[31:0]: total cycles from start acceptance to done. It saturates at 0xFFFFFFFF and clears on start.
  - Adds output perf_stall[31:0]: cycles in WLD/BLD/RUN with no counted handshake.
  - Both reset to 0.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- 1 layer, wn=4, bn=2, ns=1, continuous src handshakes → wwrite high exactly 4 beats, bwrite exactly 2 beats; run falls the cycle after the dst_last handshake; done pulses once; busy low after.
- 2 layers with different ih (28, 14) → ih output 28 through layer 0 and 14 from layer 1 LOAD onward; layer output goes 0 then 1; one done pulse total.
- Layer with wn=0, bn=0, ns=2 → WLD and BLD skipped (wwrite and bwrite never high); run stays high across 2 dst_last beats.
- cfg_we and start asserted while busy → table unchanged, sequence unperturbed, err=1; next start in IDLE clears err.
- abort during WLD after 2 of 4 beats → next cycle wwrite=0, busy=0, no done; restart replays all 4 weight beats.
- nlayers=0 → err=1, done pulse 2 cycles after start, no wwrite/bwrite/run.

Source files
------------

// File: rtl/layer_seq.sv
// Layer sequencer: walks a descriptor table and steps tiny_dnn_top through weight load, bias load and run.
// Optional LAYER_SEQ_PERF_EN adds perf_cyc/perf_stall counters.
module layer_seq #(
  parameter int MAX_LAYERS = 4,
  parameter int F_NUM      = 16,
  localparam int LW        = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [LW-1:0] cfg_idx,
  input  logic [111:0]  cfg_data,
  input  logic [LW:0]   nlayers,
  input  logic          start,
  input  logic          abort,
  input  logic          src_valid,
  input  logic          src_ready,
  input  logic          dst_valid,
  input  logic          dst_ready,
  input  logic          dst_last,
  output logic          wwrite,
  output logic          bwrite,
  output logic          run,
  output logic [11:0]   ss,
  output logic [3:0]    id,
  output logic [9:0]    is,
  output logic [4:0]    ih,
  output logic [4:0]    iw,
  output logic [11:0]   ds,
  output logic [3:0]    od,
  output logic [9:0]    os,
  output logic [4:0]    oh,
  output logic [4:0]    ow,
  output logic [7:0]    fs,
  output logic [2:0]    kh,
  output logic [2:0]    kw,
  output logic          busy,
  output logic          done,
  output logic [LW-1:0] layer,
`ifdef LAYER_SEQ_PERF_EN
  output logic [31:0]   perf_cyc,
  output logic [31:0]   perf_stall,
`endif
  output logic          err
);

  typedef enum logic [2:0] {IDLE, LOAD, WLD, BLD, RUN, NEXT, DONE} state_t;

  state_t        state, state_next;
  logic [111:0]  table_mem [MAX_LAYERS];
  logic [111:0]  desc_q;
  logic [12:0]   cnt, cnt_next, cnt_inc;
  logic [LW-1:0] layer_next;
  logic [LW:0]   nl_lat;
  logic [12:0]   cur_wn;
  logic [4:0]    cur_bn, bn_lim;
  logic [7:0]    cur_ns;
  logic          bn_over, nl_bad, hs_src, hs_dst, start_ok, err_phase, err_set;

  assign ss = desc_q[11:0];
  assign id = desc_q[15:12];
  assign is = desc_q[25:16];
  assign ih = desc_q[30:26];
  assign iw = desc_q[35:31];
  assign ds = desc_q[47:36];
  assign od = desc_q[51:48];
  assign os = desc_q[61:52];
  assign oh = desc_q[66:62];
  assign ow = desc_q[71:67];
  assign fs = desc_q[79:72];
  assign kh = desc_q[82:80];
  assign kw = desc_q[85:83];

  assign cur_wn  = desc_q[98:86];
  assign cur_bn  = desc_q[103:99];
  assign cur_ns  = desc_q[111:104];
  assign bn_over = cur_bn > 5'(F_NUM);
  assign bn_lim  = bn_over ? 5'(F_NUM) : cur_bn;
  assign nl_bad  = (nl_lat == '0) || (nl_lat > (LW+1)'(MAX_LAYERS));
  assign hs_src  = src_valid & src_ready;
  assign hs_dst  = dst_valid & dst_ready & dst_last;
  assign cnt_inc = cnt + 13'd1;
  assign start_ok = (state == IDLE) && start && !abort;
  assign err_set  = err_phase || (cfg_we && state != IDLE);

  always_ff @(posedge clk) begin
    if (cfg_we && state == IDLE)
      table_mem[cfg_idx] <= cfg_data;
  end

  // Beat counter is cleared on every phase exit, so it always starts at 0 on entry.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    layer_next = layer;
    err_phase  = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_next = LOAD;
        layer_next = '0;
      end
      LOAD: begin
        if (nl_bad || cur_ns == 8'd0) begin
          err_phase  = 1'b1;
          state_next = DONE;
        end else begin
          err_phase = bn_over;
          if (cur_wn != 13'd0)      state_next = WLD;
          else if (bn_lim != 5'd0)  state_next = BLD;
          else                      state_next = RUN;
        end
      end
      WLD: if (hs_src) begin
        if (cnt_inc == cur_wn) begin
          cnt_next   = '0;
          state_next = (bn_lim != 5'd0) ? BLD : RUN;
        end else cnt_next = cnt_inc;
      end
      BLD: if (hs_src) begin
        if (cnt_inc == {8'd0, bn_lim}) begin
          cnt_next   = '0;
          state_next = RUN;
        end else cnt_next = cnt_inc;
      end
      RUN: if (hs_dst) begin
        if (cnt_inc == {5'd0, cur_ns}) begin
          cnt_next   = '0;
          state_next = NEXT;
        end else cnt_next = cnt_inc;
      end
      NEXT: begin
        if (({1'b0, layer} + (LW+1)'(1)) < nl_lat) begin
          layer_next = layer + LW'(1);
          state_next = LOAD;
        end else state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next = IDLE;
      cnt_next   = '0;
      layer_next = layer;
      err_phase  = 1'b0;
    end
  end

  // Controls are registered off the next state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      layer  <= '0;
      nl_lat <= '0;
      desc_q <= '0;
      wwrite <= 1'b0;
      bwrite <= 1'b0;
      run    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      layer  <= layer_next;
      wwrite <= (state_next == WLD);
      bwrite <= (state_next == BLD);
      run    <= (state_next == RUN);
      busy   <= (state_next != IDLE);
      done   <= (state_next == DONE);
      if (start_ok) nl_lat <= nlayers;
      if (state_next == LOAD && state != LOAD) desc_q <= table_mem[layer_next];
      if (start_ok)     err <= 1'b0;
      else if (err_set) err <= 1'b1;
    end
  end

`ifdef LAYER_SEQ_PERF_EN
  logic stall;
  assign stall = ((state == WLD || state == BLD) && !hs_src) || (state == RUN && !hs_dst);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cyc   <= '0;
      perf_stall <= '0;
    end else begin
      if (start_ok)                              perf_cyc <= '0;
      else if (state != IDLE && perf_cyc != '1)  perf_cyc <= perf_cyc + 32'd1;
      if (stall && perf_stall != '1)             perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_layer_seq.sv
// Directed self-checking bench for layer_seq (default build, LAYER_SEQ_PERF_EN undefined).
module tb_layer_seq;
  localparam int MAX_LAYERS = 4;
  localparam int LW = 2;
  localparam logic [85:0] GEO_PAT = 86'h15_6789_ABCD_EF01_2345_6789;

  logic          clk, rst_n;
  logic          cfg_we;
  logic [LW-1:0] cfg_idx;
  logic [111:0]  cfg_data;
  logic [LW:0]   nlayers;
  logic          start, abort;
  logic          src_valid, src_ready, dst_valid, dst_ready, dst_last;
  logic          wwrite, bwrite, run, busy, done, err;
  logic [11:0]   ss, ds;
  logic [3:0]    id, od;
  logic [9:0]    is, os;
  logic [4:0]    ih, iw, oh, ow;
  logic [7:0]    fs;
  logic [2:0]    kh, kw;
  logic [LW-1:0] layer;

  int checks = 0;
  int errors = 0;
  int w_cnt = 0, b_cnt = 0, r_cnt = 0, d_cnt = 0;
  int w0, b0, r0, d0;
  int l1_seen;
  logic [111:0] exp_d;

  layer_seq #(.MAX_LAYERS(MAX_LAYERS), .F_NUM(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .nlayers(nlayers), .start(start), .abort(abort),
    .src_valid(src_valid), .src_ready(src_ready),
    .dst_valid(dst_valid), .dst_ready(dst_ready), .dst_last(dst_last),
    .wwrite(wwrite), .bwrite(bwrite), .run(run),
    .ss(ss), .id(id), .is(is), .ih(ih), .iw(iw), .ds(ds), .od(od), .os(os),
    .oh(oh), .ow(ow), .fs(fs), .kh(kh), .kw(kw),
    .busy(busy), .done(done), .layer(layer), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wwrite) w_cnt++;
      if (bwrite) b_cnt++;
      if (run)    r_cnt++;
      if (done)   d_cnt++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [111:0] mkDesc(input logic [4:0] ihv, input logic [12:0] wn,
                                          input logic [4:0] bn, input logic [7:0] ns);
    logic [111:0] d;
    d = '0;
    d[85:0]    = GEO_PAT;
    d[30:26]   = ihv;
    d[98:86]   = wn;
    d[103:99]  = bn;
    d[111:104] = ns;
    return d;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic sv, input logic sr, input logic dv,
                               input logic dr, input logic dl);
    src_valid = sv;
    src_ready = sr;
    dst_valid = dv;
    dst_ready = dr;
    dst_last  = dl;
  endtask

  task automatic writeDesc(input logic [LW-1:0] idx, input logic [111:0] d);
    cfg_we = 1'b1; cfg_idx = idx; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulseStart(input logic [LW:0] nl);
    nlayers = nl;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic snap();
    w0 = w_cnt; b0 = b_cnt; r0 = r_cnt; d0 = d_cnt;
  endtask

  task automatic waitDone(input string tag, input int limit);
    int n;
    n = 0;
    while (!done && n < limit) begin
      tick();
      n++;
    end
    checkOutput(tag, done, 1);
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_data = '0; nlayers = '0;
    start = 1'b0; abort = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    tick(); tick();
    checkOutput("rst_ctrl", {wwrite, bwrite, run, busy, done, err}, 6'b0);
    checkOutput("rst_geo", {kw, kh, fs, ow, oh, os, od, ds, iw, ih, is, id, ss}, 86'd0);
    checkOutput("rst_layer", layer, 0);
    #3 rst_n = 1'b1;
    tick();

    $display("[TB] test 1: single layer wn=4 bn=2 ns=1");
    writeDesc(0, mkDesc(5'd28, 13'd4, 5'd2, 8'd1));
    applyStimulus(1, 1, 0, 0, 0);
    snap();
    pulseStart(1);
    checkOutput("t1_load_busy", {busy, wwrite}, 2'b10);
    exp_d = mkDesc(5'd28, 13'd4, 5'd2, 8'd1);
    checkOutput("t1_geo", {kw, kh, fs, ow, oh, os, od, ds, iw, ih, is, id, ss}, exp_d[85:0]);
    tick();
    checkOutput("t1_wwrite_lat", wwrite, 1);
    for (int n = 0; n < 20 && !run; n++) tick();
    checkOutput("t1_run_up", run, 1);
    checkOutput("t1_w_beats", w_cnt - w0, 4);
    checkOutput("t1_b_beats", b_cnt - b0, 2);
    tick(); tick();
    checkOutput("t1_run_hold", run, 1);
    applyStimulus(0, 0, 1, 1, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t1_run_fall", run, 0);
    tick();
    checkOutput("t1_done", {done, busy}, 2'b11);
    tick();
    checkOutput("t1_idle", {done, busy}, 2'b00);
    checkOutput("t1_r_cycles", r_cnt - r0, 3);
    checkOutput("t1_done_cnt", d_cnt - d0, 1);

    $display("[TB] test 2: two layers ih 28 then 14");
    writeDesc(0, mkDesc(5'd28, 13'd1, 5'd1, 8'd1));
    writeDesc(1, mkDesc(5'd14, 13'd1, 5'd1, 8'd1));
    applyStimulus(1, 1, 1, 1, 1);
    snap();
    l1_seen = 0;
    pulseStart(2);
    for (int n = 0; n < 60; n++) begin
      if (busy && !done) begin
        checkOutput("t2_ih_layer", ih, (layer == 2'd0) ? 28 : 14);
        if (layer == 2'd1) l1_seen++;
      end
      if (done) break;
      tick();
    end
    checkOutput("t2_done_seen", done, 1);
    checkOutput("t2_layer1_seen", (l1_seen > 0), 1);
    tick();
    checkOutput("t2_done_cnt", d_cnt - d0, 1);
    checkOutput("t2_w_beats", w_cnt - w0, 2);

    $display("[TB] test 3: wn=0 bn=0 ns=2");
    writeDesc(0, mkDesc(5'd10, 13'd0, 5'd0, 8'd2));
    applyStimulus(1, 1, 0, 0, 0);
    snap();
    pulseStart(1);
    tick();
    checkOutput("t3_run_lat", run, 1);
    tick();
    applyStimulus(1, 1, 1, 1, 1);
    tick();
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("t3_run_after1", run, 1);
    tick();
    checkOutput("t3_run_between", run, 1);
    applyStimulus(1, 1, 1, 1, 1);
    tick();
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("t3_run_after2", run, 0);
    waitDone("t3_done", 10);
    tick();
    checkOutput("t3_no_wb", (w_cnt - w0) + (b_cnt - b0), 0);

    $display("[TB] test 4: cfg_we and start while busy");
    writeDesc(0, mkDesc(5'd22, 13'd3, 5'd1, 8'd1));
    applyStimulus(1, 1, 1, 1, 1);
    snap();
    pulseStart(1);
    cfg_we = 1'b1; cfg_idx = 0; cfg_data = mkDesc(5'd5, 13'd7, 5'd1, 8'd1); start = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    checkOutput("t4_err_set", err, 1);
    waitDone("t4_done", 30);
    checkOutput("t4_ih_kept", ih, 22);
    tick();
    checkOutput("t4_w_beats", w_cnt - w0, 3);
    checkOutput("t4_done_cnt", d_cnt - d0, 1);
    snap();
    pulseStart(1);
    checkOutput("t4_err_clear", err, 0);
    checkOutput("t4_table_kept", ih, 22);
    waitDone("t4_done2", 30);
    tick();
    checkOutput("t4_w_beats2", w_cnt - w0, 3);

    $display("[TB] test 5: abort in WLD");
    writeDesc(0, mkDesc(5'd20, 13'd4, 5'd0, 8'd1));
    applyStimulus(1, 1, 1, 1, 1);
    snap();
    pulseStart(1);
    tick(); tick(); tick();
    checkOutput("t5_in_wld", wwrite, 1);
    abort = 1'b1;
    applyStimulus(0, 0, 1, 1, 1);
    tick();
    abort = 1'b0;
    checkOutput("t5_abort", {wwrite, busy, done}, 3'b000);
    tick(); tick(); tick();
    checkOutput("t5_no_done", d_cnt - d0, 0);
    checkOutput("t5_geo_hold", ih, 20);
    applyStimulus(1, 1, 1, 1, 1);
    snap();
    pulseStart(1);
    waitDone("t5_done", 30);
    tick();
    checkOutput("t5_replay", w_cnt - w0, 4);

    $display("[TB] test 6: nlayers 0 and 5");
    snap();
    pulseStart(0);
    checkOutput("t6_load", {busy, done}, 2'b10);
    tick();
    checkOutput("t6_done", {done, err}, 2'b11);
    tick();
    checkOutput("t6_idle", busy, 0);
    checkOutput("t6_no_ctrl", (w_cnt - w0) + (b_cnt - b0) + (r_cnt - r0), 0);
    pulseStart(5);
    checkOutput("t6b_err_clr", err, 0);
    tick();
    checkOutput("t6b_done", {done, err}, 2'b11);
    tick();

    $display("[TB] test 7: bn above F_NUM clamps");
    writeDesc(0, mkDesc(5'd3, 13'd0, 5'd20, 8'd1));
    applyStimulus(1, 1, 1, 1, 1);
    snap();
    pulseStart(1);
    waitDone("t7_done", 40);
    tick();
    checkOutput("t7_b_beats", b_cnt - b0, 16);
    checkOutput("t7_err", err, 1);

    $display("[TB] test 8: ns=0 illegal");
    writeDesc(0, mkDesc(5'd3, 13'd2, 5'd1, 8'd0));
    snap();
    pulseStart(1);
    tick();
    checkOutput("t8_done", {done, err}, 2'b11);
    tick();
    checkOutput("t8_no_ctrl", (w_cnt - w0) + (b_cnt - b0) + (r_cnt - r0), 0);

    $display("[TB] test 9: abort beats start");
    writeDesc(0, mkDesc(5'd3, 13'd2, 5'd1, 8'd1));
    nlayers = 1; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    checkOutput("t9_idle", busy, 0);

    $display("[TB] test 10: async reset mid-sequence");
    applyStimulus(1, 1, 0, 0, 0);
    pulseStart(1);
    tick();
    checkOutput("t10_in_wld", wwrite, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t10_reset", {wwrite, busy, done, err, ih}, 9'd0);
    #2 rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
